// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store initiator: op codes, exception codes and FSM states.
// Op bits [1:0] give the access size, bit 2 selects zero-extension and bit 3 marks a store.
package lsu_pkg;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LH  = 4'd1;
  localparam logic [3:0] OP_LW  = 4'd2;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_LD_MIS  = 2'b01;
  localparam logic [1:0] EXC_ST_MIS  = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: op_legal = 1'b1;
      default:                                                  op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
    case (op[1:0])
      2'd1:    op_misaligned = addr_lo[0];
      2'd2:    op_misaligned = (addr_lo != 2'b00);
      default: op_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for a 32-bit little-endian RAM port: store lane selects and
// replication, plus load lane extraction with sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  size_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata[{addr_lo, 3'b000} +: 8];
  assign half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // size_op[2] set means zero-extend (LBU/LHU)
  always_comb begin
    sel       = 4'b0000;
    wdata_rep = '0;
    load_data = '0;
    case (size_op[1:0])
      2'd0: begin
        sel       = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        load_data = size_op[2] ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      end
      2'd1: begin
        sel       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        load_data = size_op[2] ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      end
      default: begin
        sel       = 4'b1111;
        wdata_rep = wdata;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Non-pipelined load/store initiator: one op in flight, one RAM bus cycle per legal op.
//   state     | meaning
//   ST_IDLE   | ready for a new op (once out of reset)
//   ST_ACCESS | single RAM bus cycle; load data captured at its closing edge
//   ST_RESP   | response presented and held until resp_ready or flush
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [RD_W-1:0]   req_rd,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [RD_W-1:0]   resp_rd,
  output logic              resp_we,
  output logic [1:0]        resp_exc,
  output logic [ADDR_W-1:0] resp_badaddr,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_sel,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  lsu_state_e        state_q, state_d;
  logic              ready_en_q;
  logic              accept;
  logic [1:0]        req_exc;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [RD_W-1:0]   rd_q;
  logic [3:0]        lane_sel;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] load_data;
  logic              in_access;

  always_comb begin
    req_exc = EXC_NONE;
    if (!op_legal(req_op))
      req_exc = EXC_ILLEGAL;
    else if (op_misaligned(req_op, req_addr[1:0]))
      req_exc = req_op[3] ? EXC_ST_MIS : EXC_LD_MIS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ready_en_q keeps req_ready low until the first edge after reset release
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = ready_en_q;
        if (ready_en_q && req_valid && !flush) begin
          accept  = 1'b1;
          state_d = (req_exc != EXC_NONE) ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = flush ? ST_IDLE : ST_RESP;
      ST_RESP: begin
        resp_valid = 1'b1;
        if (flush || resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  lsu_lane_align u_lane_align (
    .size_op   (op_q[2:0]),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (ram_rdata),
    .sel       (lane_sel),
    .wdata_rep (lane_wdata),
    .load_data (load_data)
  );

  assign in_access = (state_q == ST_ACCESS);
  assign ram_ce    = in_access;
  assign ram_we    = in_access & op_q[3];
  assign ram_addr  = in_access ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign ram_sel   = in_access ? lane_sel : 4'b0000;
  assign ram_wdata = in_access ? lane_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q   <= 1'b0;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      resp_rdata   <= '0;
      resp_rd      <= '0;
      resp_we      <= 1'b0;
      resp_exc     <= EXC_NONE;
      resp_badaddr <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rd_q    <= req_rd;
        if (req_exc != EXC_NONE) begin
          resp_rdata   <= '0;
          resp_rd      <= req_rd;
          resp_we      <= 1'b0;
          resp_exc     <= req_exc;
          resp_badaddr <= req_addr;
        end
      end
      // a flushed access still hits the RAM but leaves the response registers alone
      if (in_access && !flush) begin
        resp_rdata   <= op_q[3] ? '0 : load_data;
        resp_rd      <= rd_q;
        resp_we      <= !op_q[3];
        resp_exc     <= EXC_NONE;
        resp_badaddr <= '0;
      end
      if (state_q == ST_RESP && (flush || resp_ready))
        resp_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Randomized bench for lsu_mem_initiator against a byte-array memory model and
// size/sign rules computed arithmetically from the op code.
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        flush;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_we;
  logic [1:0]  resp_exc;
  logic [31:0] resp_badaddr;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr;
  logic [3:0]  ram_sel;
  logic [31:0] ram_wdata, ram_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] ram [256];
  logic [7:0]  ref_mem [1024];
  logic [3:0]  legal_ops [8];

  always #5 clk = ~clk;

  lsu_mem_initiator #(.ADDR_W(32), .DATA_W(32), .RD_W(5)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_rd       (req_rd),
    .flush        (flush),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_rd      (resp_rd),
    .resp_we      (resp_we),
    .resp_exc     (resp_exc),
    .resp_badaddr (resp_badaddr),
    .ram_ce       (ram_ce),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_sel      (ram_sel),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  // Environment RAM: combinational read, byte-masked synchronous write
  assign ram_rdata = ram[ram_addr[9:2]];
  always @(posedge clk) begin
    if (ram_ce && ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) ram[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int op_bytes(input logic [3:0] op);
    return (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic op_ok(input logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10};
  endfunction

  task automatic drive_req(input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    req_rd    = rd;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input int hold);
    int          nb;
    logic        mis;
    logic [4:0]  rd;
    logic [31:0] e_rdata, e_bad, wrep;
    logic [1:0]  e_exc;
    logic        e_we;
    logic [3:0]  e_sel;
    nb  = op_bytes(op);
    mis = (addr % nb) != 0;
    rd  = 5'($urandom);
    e_rdata = 0; e_bad = 0; e_exc = 2'b00; e_we = 1'b0;
    drive_req(op, addr, wd, rd);
    chk("req_ready_idle", {31'b0, req_ready}, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!op_ok(op) || mis) begin
      e_exc = !op_ok(op) ? 2'b11 : (op[3] ? 2'b10 : 2'b01);
      e_bad = addr;
      chk("exc_no_ram_ce", {31'b0, ram_ce}, 0);
      chk("exc_resp_valid", {31'b0, resp_valid}, 1);
    end else begin
      e_sel = 4'(((1 << nb) - 1) << addr[1:0]);
      for (int i = 0; i < 4; i++) wrep[8*i +: 8] = wd[8*(i % nb) +: 8];
      chk("acc_ram_ce", {31'b0, ram_ce}, 1);
      chk("acc_ram_we", {31'b0, ram_we}, {31'b0, op[3]});
      chk("acc_ram_addr", ram_addr, addr & ~32'd3);
      chk("acc_ram_sel", {28'b0, ram_sel}, {28'b0, e_sel});
      chk("acc_resp_valid", {31'b0, resp_valid}, 0);
      if (op[3]) begin
        chk("acc_ram_wdata", ram_wdata, wrep);
        for (int i = 0; i < nb; i++) ref_mem[addr[9:0] + 10'(i)] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) e_rdata[8*i +: 8] = ref_mem[addr[9:0] + 10'(i)];
        if (!op[2] && nb < 4 && e_rdata[8*nb-1]) e_rdata = e_rdata | ~((32'd1 << (8*nb)) - 1);
        e_we = 1'b1;
      end
      @(posedge clk); #1;
      chk("resp_valid_lat", {31'b0, resp_valid}, 1);
      chk("after_acc_ram_ce", {31'b0, ram_ce}, 0);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_resp_valid", {31'b0, resp_valid}, 1);
      chk("hold_req_ready", {31'b0, req_ready}, 0);
      chk("hold_rdata", resp_rdata, e_rdata);
      chk("hold_exc", {30'b0, resp_exc}, {30'b0, e_exc});
    end
    chk("resp_rdata", resp_rdata, e_rdata);
    chk("resp_rd", {27'b0, resp_rd}, {27'b0, rd});
    chk("resp_we", {31'b0, resp_we}, {31'b0, e_we});
    chk("resp_exc", {30'b0, resp_exc}, {30'b0, e_exc});
    chk("resp_badaddr", resp_badaddr, e_bad);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("resp_done_valid", {31'b0, resp_valid}, 0);
    chk("resp_done_we", {31'b0, resp_we}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w, a;
    logic [3:0]  op;
    int          r;
    legal_ops = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10};
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      ram[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
    end
    rst_n = 1'b0; req_valid = 1'b0; req_op = 0; req_addr = 0; req_wdata = 0;
    req_rd = 0; flush = 1'b0; resp_ready = 1'b0;
    #3;
    chk("rst_req_ready", {31'b0, req_ready}, 0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 0);
    chk("rst_ram_ce", {31'b0, ram_ce}, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_we", {31'b0, resp_we}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", {31'b0, req_ready}, 1);

    do_op(4'd10, 32'h100, 32'hDEADBEEF, 0);
    do_op(4'd2,  32'h100, 32'h0, 1);
    do_op(4'd8,  32'h103, 32'h80, 0);
    do_op(4'd0,  32'h103, 32'h0, 0);
    do_op(4'd4,  32'h103, 32'h0, 2);
    do_op(4'd9,  32'h202, 32'h1234, 0);
    do_op(4'd5,  32'h202, 32'h0, 0);
    do_op(4'd2,  32'h200, 32'h0, 0);
    do_op(4'd2,  32'h101, 32'h0, 0);
    do_op(4'd9,  32'h301, 32'hAAAA, 0);
    do_op(4'd3,  32'h2C4, 32'h0, 3);

    // flush while in IDLE: no accept
    drive_req(4'd2, 32'h100, 32'h0, 5'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_ram_ce", {31'b0, ram_ce}, 0);
    chk("flush_idle_ready", {31'b0, req_ready}, 1);

    // flush during a store access: write lands, response suppressed
    drive_req(4'd10, 32'h3A8, 32'hCAFEF00D, 5'd2);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("flush_acc_ram_ce", {31'b0, ram_ce}, 1);
    flush = 1'b1;
    for (int i = 0; i < 4; i++) ref_mem[10'h3A8 + 10'(i)] = 8'(32'hCAFEF00D >> (8*i));
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_acc_no_resp", {31'b0, resp_valid}, 0);
    chk("flush_acc_ready", {31'b0, req_ready}, 1);
    do_op(4'd2, 32'h3A8, 32'h0, 4);

    // flush in RESP wins over resp_ready
    drive_req(4'd1, 32'h0FF, 32'h0, 5'd3);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("flush_resp_valid", {31'b0, resp_valid}, 1);
    flush = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; resp_ready = 1'b0;
    chk("flush_resp_dropped", {31'b0, resp_valid}, 0);
    chk("flush_resp_ready", {31'b0, req_ready}, 1);

    // reset during a store access drops the store
    drive_req(4'd10, 32'h3F0, 32'h5A5A5A5A, 5'd4);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_acc_ram_ce", {31'b0, ram_ce}, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_acc_ce_low", {31'b0, ram_ce}, 0);
    chk("rst_acc_valid_low", {31'b0, resp_valid}, 0);
    chk("rst_acc_ready_low", {31'b0, req_ready}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rel_ready", {31'b0, req_ready}, 1);
    do_op(4'd2, 32'h3F0, 32'h0, 0);

    for (int n = 0; n < 200; n++) begin
      r  = $urandom_range(0, 9);
      op = (r < 8) ? legal_ops[r] : 4'($urandom_range(0, 15));
      a  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 9) < 7) a = a & ~32'(op_bytes(op) - 1);
      do_op(op, a, $urandom, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
